// File: rtl/io_device_table_pkg.sv
// Shared types for the I/O-port decode table: device ids, entry record,
// config byte layout and the loader states.
package io_device_table_pkg;

    localparam int IO_CFG_BYTES = 4;
    localparam int BYTE_PORT    = 0;
    localparam int BYTE_MASK    = 1;
    localparam int BYTE_PARAM   = 2;
    localparam int BYTE_TAG     = 3;

    typedef enum logic [3:0] {
        DEV_NONE = 4'd0,
        DEV_OPL3 = 4'd1,
        DEV_SCC  = 4'd2,
        DEV_PSG  = 4'd3,
        DEV_VDP  = 4'd4,
        DEV_PPI  = 4'd5,
        DEV_RTC  = 4'd6
    } device_t;

    // tag byte is {id, num, pad}, kept raw so id/num widths stay parametric
    typedef struct packed {
        logic [7:0] port;
        logic [7:0] mask;
        logic [7:0] param;
        logic [7:0] tag;
    } io_device_t;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_ERROR = 2'd2
    } cfg_state_t;

    function automatic logic port_hit(
        input logic [7:0] addr,
        input logic [7:0] port,
        input logic [7:0] mask
    );
        return ((addr ^ port) & mask) == 8'h00;
    endfunction

endpackage

// File: rtl/io_device_table_prio.sv
// Priority resolver for the table match vector: lowest set index wins,
// and multi flags that more than one entry claimed the cycle.
module io_prio_match #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  match_i,
    output logic [IW-1:0] idx_o,
    output logic          hit_o,
    output logic          multi_o
);

    logic [IW-1:0] idx;
    logic          hit;
    logic          multi;

    always_comb begin
        idx   = '0;
        hit   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (match_i[i]) begin
                if (hit) begin
                    multi = 1'b1;
                end else begin
                    hit = 1'b1;
                    idx = IW'(i);
                end
            end
        end
    end

    assign idx_o   = idx;
    assign hit_o   = hit;
    assign multi_o = multi;

endmodule

// File: rtl/io_device_table.sv
// Boot-loaded I/O port decode table: streams 4-byte entries in, then turns
// each Z80 I/O cycle start into one registered device select.
module io_device_table
    import io_device_table_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int ID_W        = 4,
    parameter int NUM_W       = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_clear,
    input  logic                             cfg_valid,
    input  logic [7:0]                       cfg_data,
    input  logic                             cfg_last,
    output logic                             cfg_ready,
    output logic                             cfg_done,
    output logic                             cfg_error,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] entry_count,
    input  logic                             iorq,
    input  logic                             rd,
    input  logic                             wr,
    input  logic                             m1,
    input  logic [7:0]                       addr,
    output logic                             sel_strobe,
    output logic                             sel_hit,
    output logic [ID_W-1:0]                  sel_id,
    output logic [NUM_W-1:0]                 sel_num,
    output logic [7:0]                       sel_param,
    output logic                             sel_wr,
    output logic                             sel_conflict
);

    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int PAD_W = 8 - ID_W - NUM_W;

    cfg_state_t       state_q, state_d;
    logic [1:0]       bidx_q, bidx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             full;
    logic             commit;

    logic [7:0]       port_stg_q;
    logic [7:0]       mask_stg_q;
    logic [7:0]       param_stg_q;

    io_device_t       tbl_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] vld_q;

    logic [NUM_ENTRIES-1:0] match;
    logic [IDX_W-1:0] win_idx;
    logic             any_hit;
    logic             multi;
    io_device_t       win;

    logic             io_act;
    logic             io_prev_q;
    logic             io_start;

    logic             strobe_q;
    logic             hit_q;
    logic [ID_W-1:0]  id_q;
    logic [NUM_W-1:0] num_q;
    logic [7:0]       param_q;
    logic             wr_q;
    logic             conflict_q;

    logic             unused_pad;

    assign cfg_ready   = (state_q == ST_LOAD);
    assign cfg_done    = (state_q == ST_READY);
    assign cfg_error   = (state_q == ST_ERROR);
    assign entry_count = cnt_q;

    assign accept = cfg_valid & cfg_ready;
    assign full   = (cnt_q == CNT_W'(NUM_ENTRIES));

    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (bidx_q == 2'd0 && full) begin
                        state_d = ST_ERROR;
                    end else if (bidx_q == 2'(BYTE_TAG)) begin
                        commit = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        bidx_d = 2'd0;
                        if (cfg_last) state_d = ST_READY;
                    end else begin
                        bidx_d = bidx_q + 2'd1;
                        if (cfg_last) state_d = ST_ERROR;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || cfg_clear) begin
            state_q <= ST_LOAD;
            bidx_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bidx_q  <= bidx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Staging and table payload need no reset; vld_q gates every use.
    always_ff @(posedge clk) begin
        if (accept && !cfg_clear) begin
            case (bidx_q)
                2'(BYTE_PORT):  port_stg_q  <= cfg_data;
                2'(BYTE_MASK):  mask_stg_q  <= cfg_data;
                2'(BYTE_PARAM): param_stg_q <= cfg_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (commit && cnt_q == CNT_W'(i)) begin
                tbl_q[i] <= '{port:  port_stg_q,
                              mask:  mask_stg_q,
                              param: param_stg_q,
                              tag:   cfg_data};
            end
        end
    end

    // A DEV_NONE entry takes its slot but never becomes matchable.
    always_ff @(posedge clk) begin
        if (reset || cfg_clear) begin
            vld_q <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    vld_q[i] <= (cfg_data[7 -: ID_W] != ID_W'(DEV_NONE));
                end
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match[i] = vld_q[i] &
                       port_hit(addr, tbl_q[i].port, tbl_q[i].mask);
        end
    end

    io_prio_match #(
        .N  (NUM_ENTRIES),
        .IW (IDX_W)
    ) u_prio (
        .match_i (match),
        .idx_o   (win_idx),
        .hit_o   (any_hit),
        .multi_o (multi)
    );

    assign win        = tbl_q[win_idx];
    assign unused_pad = ^win.tag[PAD_W-1:0];

    assign io_act   = iorq & (rd | wr) & ~m1;
    assign io_start = io_act & ~io_prev_q;

    // io_prev_q tracks io_act through reset so a held strobe needs a new edge.
    always_ff @(posedge clk) begin
        if (reset || cfg_clear) begin
            io_prev_q  <= io_act;
            strobe_q   <= 1'b0;
            hit_q      <= 1'b0;
            id_q       <= ID_W'(DEV_NONE);
            num_q      <= '0;
            param_q    <= 8'h00;
            wr_q       <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            io_prev_q <= io_act;
            strobe_q  <= io_start;
            if (io_start) begin
                wr_q <= wr;
                if (state_q == ST_READY && any_hit) begin
                    hit_q   <= 1'b1;
                    id_q    <= win.tag[7 -: ID_W];
                    num_q   <= win.tag[7-ID_W -: NUM_W];
                    param_q <= win.param;
                    if (multi) conflict_q <= 1'b1;
                end else begin
                    hit_q   <= 1'b0;
                    id_q    <= ID_W'(DEV_NONE);
                    num_q   <= '0;
                    param_q <= 8'h00;
                end
            end
        end
    end

    assign sel_strobe   = strobe_q;
    assign sel_hit      = hit_q;
    assign sel_id       = id_q;
    assign sel_num      = num_q;
    assign sel_param    = param_q;
    assign sel_wr       = wr_q;
    assign sel_conflict = conflict_q;

endmodule

// File: tb/tb_io_device_table.sv
// Randomised scoreboard bench for io_device_table against a list-based
// reference of the loaded table and first-match decode.
module tb_io_device_table;
    import io_device_table_pkg::*;

    localparam int N     = 16;
    localparam int ID_W  = 4;
    localparam int NUM_W = 2;
    localparam int CW    = $clog2(N + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_clear = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [7:0]       cfg_data = 8'h00;
    logic             cfg_last = 1'b0;
    logic             cfg_ready;
    logic             cfg_done;
    logic             cfg_error;
    logic [CW-1:0]    entry_count;
    logic             iorq = 1'b0;
    logic             rd = 1'b0;
    logic             wr = 1'b0;
    logic             m1 = 1'b0;
    logic [7:0]       addr = 8'h00;
    logic             sel_strobe;
    logic             sel_hit;
    logic [ID_W-1:0]  sel_id;
    logic [NUM_W-1:0] sel_num;
    logic [7:0]       sel_param;
    logic             sel_wr;
    logic             sel_conflict;

    io_device_table #(
        .NUM_ENTRIES (N),
        .ID_W        (ID_W),
        .NUM_W       (NUM_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_clear    (cfg_clear),
        .cfg_valid    (cfg_valid),
        .cfg_data     (cfg_data),
        .cfg_last     (cfg_last),
        .cfg_ready    (cfg_ready),
        .cfg_done     (cfg_done),
        .cfg_error    (cfg_error),
        .entry_count  (entry_count),
        .iorq         (iorq),
        .rd           (rd),
        .wr           (wr),
        .m1           (m1),
        .addr         (addr),
        .sel_strobe   (sel_strobe),
        .sel_hit      (sel_hit),
        .sel_id       (sel_id),
        .sel_num      (sel_num),
        .sel_param    (sel_param),
        .sel_wr       (sel_wr),
        .sel_conflict (sel_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] port;
        logic [7:0] mask;
        logic [7:0] param;
        logic [3:0] id;
        logic [1:0] num;
    } ent_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] id;
        logic [1:0] num;
        logic [7:0] param;
        logic       wr;
        logic       conf;
    } exp_t;

    exp_t sb[$];
    ent_t m_tab[$];
    bit   m_ready;
    bit   m_conf;
    int   vectors;
    int   miscompares;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sel_strobe) begin
            exp_t a;
            exp_t e;
            a = '{sel_hit, sel_id, sel_num, sel_param, sel_wr, sel_conflict};
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sel_unexpected: got %h expected no strobe", a);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL sel: got hit=%0d id=%0d num=%0d par=%h wr=%0d cf=%0d expected hit=%0d id=%0d num=%0d par=%h wr=%0d cf=%0d",
                             a.hit, a.id, a.num, a.param, a.wr, a.conf,
                             e.hit, e.id, e.num, e.param, e.wr, e.conf);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t model_expect(input logic [7:0] a, input bit w);
        exp_t e;
        int   nm;
        e    = '0;
        e.wr = w;
        nm   = 0;
        if (m_ready) begin
            foreach (m_tab[i]) begin
                if (m_tab[i].id != 4'd0 &&
                    ((a ^ m_tab[i].port) & m_tab[i].mask) == 8'h00) begin
                    if (nm == 0) begin
                        e.hit   = 1'b1;
                        e.id    = m_tab[i].id;
                        e.num   = m_tab[i].num;
                        e.param = m_tab[i].param;
                    end
                    nm++;
                end
            end
        end
        if (nm > 1) m_conf = 1'b1;
        e.conf = m_conf;
        return e;
    endfunction

    function automatic ent_t mk(input logic [7:0] p, input logic [7:0] m,
                                input logic [7:0] par, input logic [3:0] id,
                                input logic [1:0] n);
        ent_t e;
        e.port = p; e.mask = m; e.param = par; e.id = id; e.num = n;
        return e;
    endfunction

    function automatic ent_t rnd_ent(input bit allow_none);
        ent_t e;
        e.port = 8'($urandom);
        case ($urandom_range(0, 3))
            0:       e.mask = 8'hFF;
            1:       e.mask = 8'hF0;
            2:       e.mask = 8'hFE;
            default: e.mask = 8'($urandom);
        endcase
        e.param = 8'($urandom);
        if (allow_none && $urandom_range(0, 5) == 0) e.id = 4'd0;
        else e.id = 4'($urandom_range(1, 6));
        e.num = 2'($urandom);
        return e;
    endfunction

    task automatic model_clear();
        m_tab.delete();
        m_ready = 1'b0;
        m_conf  = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        cfg_clear = 1'b1;
        @(negedge clk);
        cfg_clear = 1'b0;
        model_clear();
    endtask

    task automatic load(input ent_t img[$], input int trunc);
        logic [7:0] bytes[$];
        int nb;
        int k;
        int fe;
        int exp_fe;
        fe = -99;
        foreach (img[i]) begin
            bytes.push_back(img[i].port);
            bytes.push_back(img[i].mask);
            bytes.push_back(img[i].param);
            bytes.push_back({img[i].id, img[i].num, 2'b00});
        end
        nb = (trunc >= 0) ? trunc + 1 : bytes.size();
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            if (cfg_error && fe == -99) fe = b - 1;
            cfg_valid = 1'b1;
            cfg_data  = bytes[b];
            cfg_last  = (b == nb - 1);
        end
        @(negedge clk);
        if (cfg_error && fe == -99) fe = nb - 1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        if (trunc >= 0) begin
            k = trunc / IO_CFG_BYTES; m_ready = 1'b0; exp_fe = trunc;
        end else if (img.size() > N) begin
            k = N; m_ready = 1'b0; exp_fe = IO_CFG_BYTES * N;
        end else begin
            k = img.size(); m_ready = 1'b1; exp_fe = -99;
        end
        m_tab.delete();
        for (int i = 0; i < k; i++) m_tab.push_back(img[i]);
        @(negedge clk);
        chk("load_err_byte", fe, exp_fe);
        chk("entry_count", int'(entry_count), m_tab.size());
        chk("cfg_done", int'(cfg_done), int'(m_ready));
        chk("cfg_error", int'(cfg_error), int'(!m_ready));
    endtask

    task automatic io(input logic [7:0] a, input bit w, input bit inta);
        @(negedge clk);
        iorq = 1'b1;
        m1   = inta;
        rd   = !w;
        wr   = w;
        addr = a;
        if (!inta) sb.push_back(model_expect(a, w));
        repeat (2) @(negedge clk);
        iorq = 1'b0;
        rd   = 1'b0;
        wr   = 1'b0;
        m1   = 1'b0;
        addr = 8'($urandom);
    endtask

    initial begin
        ent_t img[$];
        logic [7:0] a;
        vectors     = 0;
        miscompares = 0;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_done", int'(cfg_done), 0);
        chk("rst_error", int'(cfg_error), 0);
        chk("rst_count", int'(entry_count), 0);
        chk("rst_strobe", int'(sel_strobe), 0);
        chk("rst_hit", int'(sel_hit), 0);
        chk("rst_id", int'(sel_id), int'(DEV_NONE));
        chk("rst_conflict", int'(sel_conflict), 0);

        img = '{mk(8'hA0, 8'hFE, 8'h00, DEV_OPL3, 2'd1),
                mk(8'h7C, 8'hFE, 8'h55, DEV_PSG, 2'd2)};
        load(img, -1);
        io(8'hA1, 1'b1, 1'b0);
        io(8'h7D, 1'b0, 1'b0);
        io(8'h99, 1'b0, 1'b0);

        do_clear();
        img = '{mk(8'hA0, 8'hF0, 8'h3C, DEV_SCC, 2'd0),
                mk(8'hA2, 8'hFF, 8'h77, DEV_VDP, 2'd3)};
        load(img, -1);
        io(8'hA2, 1'b0, 1'b0);
        io(8'h10, 1'b1, 1'b0);

        @(negedge clk);
        iorq = 1'b1; rd = 1'b1; addr = 8'hA2;
        sb.push_back(model_expect(8'hA2, 1'b0));
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
        chk("held_rst_strobe", int'(sel_strobe), 0);
        chk("held_rst_hit", int'(sel_hit), 0);
        chk("held_rst_id", int'(sel_id), int'(DEV_NONE));
        chk("held_rst_conflict", int'(sel_conflict), 0);
        chk("held_rst_count", int'(entry_count), 0);
        repeat (4) @(negedge clk);
        iorq = 1'b0; rd = 1'b0;
        io(8'hA2, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n;
            do_clear();
            img.delete();
            n = $urandom_range(1, N);
            for (int i = 0; i < n; i++) img.push_back(rnd_ent(1'b1));
            load(img, -1);
            for (int j = 0; j < 12; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    a = 8'($urandom);
                end else begin
                    int s;
                    s = $urandom_range(0, n - 1);
                    a = (img[s].port & img[s].mask) |
                        (8'($urandom) & ~img[s].mask);
                end
                io(a, 1'($urandom), 1'b0);
            end
        end

        do_clear();
        img.delete();
        for (int i = 0; i < N + 1; i++) img.push_back(rnd_ent(1'b0));
        load(img, -1);
        io(img[0].port, 1'b1, 1'b0);

        do_clear();
        img = '{mk(8'h20, 8'hFF, 8'h01, DEV_PSG, 2'd0),
                mk(8'h30, 8'hFF, 8'h02, DEV_VDP, 2'd0)};
        load(img, 2);
        io(8'h20, 1'b0, 1'b0);

        do_clear();
        @(negedge clk);
        cfg_valid = 1'b1; cfg_data = 8'h11;
        @(negedge clk);
        cfg_data = 8'h22;
        @(negedge clk);
        cfg_clear = 1'b1; cfg_data = 8'h33;
        @(negedge clk);
        cfg_clear = 1'b0; cfg_valid = 1'b0;
        model_clear();
        img = '{mk(8'h3C, 8'hFF, 8'h9A, DEV_RTC, 2'd2)};
        load(img, -1);
        io(8'h3C, 1'b1, 1'b0);

        do_clear();
        img = '{mk(8'h40, 8'hFF, 8'h12, DEV_PPI, 2'd0),
                mk(8'h50, 8'hFF, 8'h34, DEV_NONE, 2'd3),
                mk(8'h00, 8'h00, 8'hEE, DEV_VDP, 2'd1)};
        load(img, -1);
        io(8'h40, 1'b0, 1'b1);
        io(8'h50, 1'b0, 1'b0);
        io(8'h40, 1'b1, 1'b0);
        io(8'h66, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
